sheffer_stroke: RTL and testbench

Universal-gate logic unit built on the Sheffer stroke (NAND). It provides a purely combinational NAND output `c`. It also provides a registered result `y` that applies a selectable Boolean function to the same operands, built exclusively from 2-input NAND cells. It is a leaf block used wherever the design needs a NAND-derived primitive, with an optional pipelined result.

---
 rtl/sheffer_pkg.sv | 17 +
 rtl/sheffer_cell.sv | 12 +
 rtl/sheffer_stroke.sv | 68 ++++++
 tb/tb_sheffer_stroke.sv | 115 +++++++++++
 4 files changed

// File: rtl/sheffer_pkg.sv
// Shared types for the NAND-derived logic unit: function select encoding.
package sheffer_pkg;

  localparam int OP_COUNT = 8;

  typedef enum logic [2:0] {
    OP_NAND = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_BUFA = 3'd7
  } op_e;

endpackage

// File: rtl/sheffer_cell.sv
// Bitwise 2-input NAND primitive; every function in the unit is built from these.
module sheffer_cell #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = ~(a & b);

endmodule

// File: rtl/sheffer_stroke.sv
// NAND-only logic unit: combinational NAND on c, op-selected function registered on y.
module sheffer_stroke
  import sheffer_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  input  logic [2:0]       op,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  logic [WIDTH-1:0] n_ab, not_a, not_b;
  logic [WIDTH-1:0] f_and, f_or, f_nor;
  logic [WIDTH-1:0] x_a, x_b, f_xor, f_xnor, f_buf;
  logic [WIDTH-1:0] f_sel;
  logic [1:0]       vld_pipe;

  sheffer_cell #(.WIDTH(WIDTH)) u_nab  (.a(a),     .b(b),     .y(n_ab));
  sheffer_cell #(.WIDTH(WIDTH)) u_nota (.a(a),     .b(a),     .y(not_a));
  sheffer_cell #(.WIDTH(WIDTH)) u_notb (.a(b),     .b(b),     .y(not_b));
  sheffer_cell #(.WIDTH(WIDTH)) u_and  (.a(n_ab),  .b(n_ab),  .y(f_and));
  sheffer_cell #(.WIDTH(WIDTH)) u_or   (.a(not_a), .b(not_b), .y(f_or));
  sheffer_cell #(.WIDTH(WIDTH)) u_nor  (.a(f_or),  .b(f_or),  .y(f_nor));
  // Classic 4-NAND XOR, sharing n_ab as the first stage
  sheffer_cell #(.WIDTH(WIDTH)) u_xa   (.a(a),     .b(n_ab),  .y(x_a));
  sheffer_cell #(.WIDTH(WIDTH)) u_xb   (.a(b),     .b(n_ab),  .y(x_b));
  sheffer_cell #(.WIDTH(WIDTH)) u_xor  (.a(x_a),   .b(x_b),   .y(f_xor));
  sheffer_cell #(.WIDTH(WIDTH)) u_xnor (.a(f_xor), .b(f_xor), .y(f_xnor));
  sheffer_cell #(.WIDTH(WIDTH)) u_buf  (.a(not_a), .b(not_a), .y(f_buf));

  assign c = n_ab;

  always_comb begin
    f_sel = n_ab;
    case (op_e'(op))
      OP_NAND: f_sel = n_ab;
      OP_AND:  f_sel = f_and;
      OP_OR:   f_sel = f_or;
      OP_NOR:  f_sel = f_nor;
      OP_XOR:  f_sel = f_xor;
      OP_XNOR: f_sel = f_xnor;
      OP_NOTA: f_sel = not_a;
      OP_BUFA: f_sel = f_buf;
      default: f_sel = n_ab;
    endcase
  end

  assign vld_pipe[0] = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      y           <= '0;
      vld_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (en) y <= f_sel;
    end
  end

  assign y_valid = vld_pipe[1];

endmodule

// File: tb/tb_sheffer_stroke.sv
// Directed checks of the NAND unit at WIDTH=1 and WIDTH=8 against hand-computed tables.
module tb_sheffer_stroke;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [2:0] op;
  logic       a1, b1, c1, y1, yv1;
  logic [7:0] a8, b8, c8, y8;
  logic       yv8;
  int         total = 0;
  int         bad = 0;

  // Truth per op, bit index = {a,b}
  logic [3:0] tt [8] = '{4'b0111, 4'b1000, 4'b1110, 4'b0001,
                         4'b0110, 4'b1001, 4'b0011, 4'b1100};

  always #5 clk = ~clk;

  sheffer_stroke #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1),
    .op(op), .en(en), .y(y1), .y_valid(yv1)
  );

  sheffer_stroke #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8),
    .op(op), .en(en), .y(y8), .y_valid(yv8)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] row;
    logic [1:0] ab;
    rst = 1'b0; en = 1'b0; op = 3'd0;
    a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;

    // combinational truth table
    a1 = 1'b1; b1 = 1'b1; #10; chk("c11", {7'd0, c1}, 8'h00);
    a1 = 1'b0; b1 = 1'b0; #10; chk("c00", {7'd0, c1}, 8'h01);
    a1 = 1'b1; b1 = 1'b0; #10; chk("c10", {7'd0, c1}, 8'h01);
    a1 = 1'b0; b1 = 1'b1; #10; chk("c01", {7'd0, c1}, 8'h01);

    // reset with en asserted
    rst = 1'b1; en = 1'b1; a1 = 1'b1; b1 = 1'b1; op = 3'd7;
    a8 = 8'hFF; b8 = 8'hFF;
    step(); step();
    chk("rst_y1",  {7'd0, y1},  8'h00);
    chk("rst_v1",  {7'd0, yv1}, 8'h00);
    chk("rst_c1",  {7'd0, c1},  8'h00);
    chk("rst_y8",  y8,          8'h00);
    chk("rst_v8",  {7'd0, yv8}, 8'h00);
    rst = 1'b0; en = 1'b0;
    step();

    // every op, every operand pair
    for (int o = 0; o < 8; o++) begin
      for (int p = 0; p < 4; p++) begin
        ab = p[1:0];
        row = tt[o];
        op = o[2:0]; a1 = ab[1]; b1 = ab[0]; en = 1'b1;
        step();
        chk($sformatf("op%0d_ab%0d_y", o, p), {7'd0, y1}, {7'd0, row[ab]});
        chk($sformatf("op%0d_ab%0d_v", o, p), {7'd0, yv1}, 8'h01);
      end
    end
    en = 1'b0;
    step();
    chk("vld_drop", {7'd0, yv1}, 8'h00);

    // hold while disabled
    op = 3'd1; a1 = 1'b1; b1 = 1'b1; en = 1'b1;
    step();
    chk("hold_cap", {7'd0, y1}, 8'h01);
    en = 1'b0; a1 = 1'b0; op = 3'd3;
    step();
    chk("hold_y", {7'd0, y1},  8'h01);
    chk("hold_v", {7'd0, yv1}, 8'h00);
    step();
    chk("hold_y2", {7'd0, y1}, 8'h01);

    // WIDTH=8 bitwise
    a8 = 8'hF0; b8 = 8'hCC; #1;
    chk("w8_c", c8, 8'h3F);
    op = 3'd2; en = 1'b1; step(); chk("w8_or", y8, 8'hFC);
    op = 3'd4;            step(); chk("w8_xor", y8, 8'h3C);
    chk("w8_v_b2b", {7'd0, yv8}, 8'h01);
    op = 3'd6;            step(); chk("w8_nota", y8, 8'h0F);

    // reset beats enable
    op = 3'd7; rst = 1'b1; en = 1'b1;
    step();
    chk("prio_y8", y8, 8'h00);
    chk("prio_v8", {7'd0, yv8}, 8'h00);
    rst = 1'b0;
    step();
    chk("post_rst_cap", y8, 8'hF0);
    chk("post_rst_v",   {7'd0, yv8}, 8'h01);
    en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
